// File: rtl/interrupt_ack_ctrl_if.sv
// -----------------------------------------------------------------------------
// interrupt_ack_ctrl_if
//   Groups the interrupt handshake between the priority encoder / CPU side and
//   the interrupt acknowledge controller.
//
//   Signals (the direction given is the controller's view):
//     int1       in   pending-interrupt flag from the priority encoder
//     x[1:0]     in   encoded source number (3 = highest), valid while int1=1
//     cpu_ack    in   CPU accepts the request presented on irq/vector
//     cpu_eoi    in   CPU signals end of interrupt service
//     irq        out  interrupt request to the CPU
//     vector     out  latched source number being requested or serviced
//     ack[3:0]   out  one-hot acknowledge to the peripherals (bit n = source n)
//     in_service out  an acknowledged interrupt is being serviced
//     err        out  one-cycle pulse on request timeout
//     irq_count  out  number of acknowledged interrupts, wraps 255 -> 0
//
//   Modports:
//     master  the encoder / CPU side (drives the requests and handshakes)
//     slave   the controller
// -----------------------------------------------------------------------------
interface interrupt_ack_ctrl_if;
  logic       int1;
  logic [1:0] x;
  logic       cpu_ack;
  logic       cpu_eoi;
  logic       irq;
  logic [1:0] vector;
  logic [3:0] ack;
  logic       in_service;
  logic       err;
  logic [7:0] irq_count;

  modport master (
    output int1, x, cpu_ack, cpu_eoi,
    input  irq, vector, ack, in_service, err, irq_count
  );

  modport slave (
    input  int1, x, cpu_ack, cpu_eoi,
    output irq, vector, ack, in_service, err, irq_count
  );
endinterface : interrupt_ack_ctrl_if

// File: rtl/interrupt_ack_ctrl.sv
// -----------------------------------------------------------------------------
// interrupt_ack_ctrl
//   Four-state interrupt acknowledge controller (IDLE -> REQ -> ACK -> SERVICE).
//   A pending interrupt seen in IDLE is latched and presented to the CPU on
//   irq/vector. The CPU accepts with cpu_ack, which produces a single-cycle
//   one-hot acknowledge to the addressed peripheral, and then closes the
//   service window with cpu_eoi. A request the CPU ignores for TIMEOUT cycles
//   is abandoned and flagged with a one-cycle err pulse. No nesting: new
//   requests are only looked at in IDLE.
//
//   Ports:
//     clk    system clock, all state changes on its rising edge
//     rst_n  asynchronous active-low reset
//     bus    interrupt_ack_ctrl_if.slave (handshake and status signals)
//
//   Parameters:
//     TIMEOUT  number of REQ cycles without cpu_ack before giving up (1..255)
//
//   Every output is a flop or a decode of flops; nothing from the inputs
//   reaches an output in the same cycle.
// -----------------------------------------------------------------------------
module interrupt_ack_ctrl #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  interrupt_ack_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_ACK     = 2'd2,
    S_SERVICE = 2'd3
  } state_e;

  // Timeout fires in the REQ cycle whose count equals TIMEOUT-1, which gives
  // exactly TIMEOUT cycles of irq when the CPU never answers.
  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  state_e     state_q,     state_d;
  logic [1:0] vector_q,    vector_d;
  logic [7:0] wait_cnt_q,  wait_cnt_d;
  logic       err_q,       err_d;
  logic [7:0] irq_count_q, irq_count_d;

  // ---------------------------------------------------------------------------
  // Next-state and register-input logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before the case so that no path leaves
    // it unassigned; a missing default here would infer a latch.
    state_d     = state_q;
    vector_d    = vector_q;
    wait_cnt_d  = wait_cnt_q;
    err_d       = 1'b0;
    irq_count_d = irq_count_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.int1) begin
          vector_d   = bus.x;
          wait_cnt_d = 8'd0;
          state_d    = S_REQ;
        end
      end

      S_REQ: begin
        // cpu_ack is tested first so it wins over a timeout in the same cycle.
        if (bus.cpu_ack) begin
          state_d     = S_ACK;
          irq_count_d = irq_count_q + 8'd1;
        end else if (wait_cnt_q == LAST_WAIT) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end

      S_ACK: begin
        state_d = bus.cpu_eoi ? S_IDLE : S_SERVICE;
      end

      S_SERVICE: begin
        if (bus.cpu_eoi) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      vector_q    <= 2'd0;
      wait_cnt_q  <= 8'd0;
      err_q       <= 1'b0;
      irq_count_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      vector_q    <= vector_d;
      wait_cnt_q  <= wait_cnt_d;
      err_q       <= err_d;
      irq_count_q <= irq_count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs, decoded from registered state only
  // ---------------------------------------------------------------------------
  assign bus.irq        = (state_q == S_REQ);
  assign bus.vector     = vector_q;
  assign bus.ack        = (state_q == S_ACK) ? (4'b0001 << vector_q) : 4'b0000;
  assign bus.in_service = (state_q == S_ACK) || (state_q == S_SERVICE);
  assign bus.err        = err_q;
  assign bus.irq_count  = irq_count_q;

endmodule : interrupt_ack_ctrl
